id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register with integrated load-use hazard detection. Sits directly upstream of the EX stage.
- Captures decoded operands, offset, register specifiers and control bits from ID each cycle, and presents them to EX one cycle later.
- On a load-use hazard, freezes PC and IF/ID and injects a one-cycle bubble into EX.
- On a branch flush, squashes the instruction entering EX.

Parameters:
- DW, 32, datapath width of RD1/RD2/OFFSET
- RW, 5, register specifier width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  RW  register specifiers from ID
- id_rd1, id_rd2  in  DW  register file read data
- id_offset  in  DW  sign-extended immediate (bits [5:0] carry funct)
- id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_memread  in  1 each  decoded control
- id_aluop  in  2  ALU op class
- flush  in  1  branch taken; squash the ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_rt, ex_rd  out  RW  to EX destination mux
- ex_rd1, ex_rd2, ex_offset  out  DW  to EX operands
- ex_alusrc, ex_regdst, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread  out  1 each
- ex_aluop  out  2
- pc_write  out  1  0 = hold PC
- ifid_write  out  1  0 = hold IF/ID register

Behaviour:
- Reset (async, active-high): every registered ex_* output goes to 0. pc_write and ifid_write are combinational and read 1 during reset, because ex_valid=0 implies no hazard.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on ex_* after edge N.
- Hazard condition: haz = ex_valid & ex_memread & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The rt compare is deliberately conservative: it applies regardless of instruction type.
- Stall (haz & !flush):
  - pc_write = 0, ifid_write = 0.
  - The next ex_* state is a bubble: ex_valid=0, all control bits 0, ex_aluop=0, data and specifiers 0.
  - Exactly one bubble per load. In the following cycle the EX load has advanced, so haz deasserts unless a new load is present.
- Flush: the next ex_* state is a bubble and pc_write = ifid_write = 1. Flush wins over a simultaneous hazard, since the stalled instruction would be squashed anyway.
- Normal (neither): pc_write = ifid_write = 1. All id_* fields are registered unchanged, and ex_valid <= id_valid.
- id_valid=0 (upstream bubble): fields still register, but control bits are forced to 0 so no memory or register side effects leak.
- Register 0: a load targeting $0 never stalls.
- Reset mid-stall: outputs clear immediately. pc_write and ifid_write return to 1 combinationally.
- No other state exists. The block is a two-state FSM on the "bubble-inserted" condition, implicit in ex_valid.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], counting cycles where the stall branch was taken (haz & !flush).
  - Saturates at 16'hFFFF and does not wrap.
  - Resets to 0.
  - Flush-only bubbles are not counted.
- When undefined: the port and counter are absent, with no other behavioural change.

Decomposition:
- Shared package mips_pkg:
  - ALUOP encodings: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
  - REG_ZERO=5'd0.
  - Control-bundle width constant CTRL_W=8.
- Sub-module hazard_detect: purely combinational, producing haz, pc_write and ifid_write from ex_valid, ex_memread, ex_rt, id_valid, id_rs, id_rt and flush.
- id_ex_pipe instantiates hazard_detect and holds all registers.

Test Plan:
- Reset: assert rst mid-cycle with ex_regwrite=1 -> all ex_* are 0 immediately (async), and pc_write=ifid_write=1.
- Pass-through: id_rd1=32'h0000_0005, id_rd2=32'h0000_0003, id_aluop=2'b10, id_regwrite=1, id_valid=1 -> the same values appear on ex_* after one edge, with ex_valid=1.
- Load-use stall:
  - Stimulus: EX holds lw with ex_rt=5'd8, then ID presents id_rs=5'd8.
  - Response: pc_write=ifid_write=0 for exactly one cycle, and the next ex_valid=0 with all control bits 0.
  - Next cycle: the same ID instruction registers normally.
- $0 load: ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
- Flush with hazard: same as the stall case but flush=1 -> pc_write=1, bubble in EX, and (with ID_EX_STALL_CNT_EN) stall_cnt unchanged.
- Counter saturation (ID_EX_STALL_CNT_EN): force stall_cnt=16'hFFFE, create two stalls -> reads 16'hFFFF and holds.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op classes, register zero and the
// packed control bundle carried from ID into EX.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CTRL_W = 8;

  // Decoded control bits, MSB first; total width is CTRL_W.
  typedef struct packed {
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection. Purely combinational: compares the load in EX
// against the source specifiers of the instruction currently in ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          flush,
  output logic          haz,
  output logic          pc_write,
  output logic          ifid_write
);

  logic stall;

  // rt is compared for every instruction type; over-stalling is harmless,
  // missing a dependency is not. A load to $0 never produces a hazard.
  assign haz = ex_valid & ex_memread & id_valid &
               (ex_rt != RW'(REG_ZERO)) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

  // A flush squashes the dependent instruction anyway, so it overrides the stall.
  assign stall      = haz & ~flush;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall and branch-flush bubbles.
// Optional feature macro: ID_EX_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles in which a load-use stall was taken.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_offset,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          id_memwrite,
  input  logic          id_memread,
  input  logic [1:0]    id_aluop,
  input  logic          flush,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rd1,
  output logic [DW-1:0] ex_rd2,
  output logic [DW-1:0] ex_offset,
  output logic          ex_alusrc,
  output logic          ex_regdst,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_memwrite,
  output logic          ex_memread,
  output logic [1:0]    ex_aluop,
  output logic          pc_write,
  output logic          ifid_write
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  ctrl_t id_ctrl, ex_ctrl;
  logic  haz, bubble;

  assign id_ctrl = '{alusrc:   id_alusrc,   regdst:   id_regdst,
                     regwrite: id_regwrite, memtoreg: id_memtoreg,
                     memwrite: id_memwrite, memread:  id_memread,
                     aluop:    id_aluop};

  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_aluop    = ex_ctrl.aluop;

  hazard_detect #(.RW(RW)) u_haz (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rt      (ex_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .flush      (flush),
    .haz        (haz),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
  );

  // Either a stall or a flush turns the next EX slot into a full bubble.
  assign bubble = haz | flush;

  // Pipeline register: bubble clears everything, otherwise capture ID and
  // gate control with id_valid so upstream bubbles cause no side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_offset <= '0;
    end else if (bubble) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_offset <= '0;
    end else begin
      ex_valid  <= id_valid;
      ex_ctrl   <= id_valid ? id_ctrl : ctrl_t'('0);
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_offset <= id_offset;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Count taken stalls only (pc_write low); saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (!pc_write && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: a reference model of the EX slot plus
// directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_id_ex_pipe;

  localparam int DW = 32;
  localparam int RW = 5;

  // Control vectors: {alusrc,regdst,regwrite,memtoreg,memwrite,memread,aluop}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LW   = 8'b1011_0100;
  localparam logic [7:0] C_ADD  = 8'b0110_0010;
  localparam logic [7:0] C_PASS = 8'b0010_0010;
  localparam logic [7:0] C_WRSW = 8'b0010_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rd1, id_rd2, id_offset;
  logic          id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_memread;
  logic [1:0]    id_aluop;
  logic          flush;
  logic          ex_valid;
  logic [RW-1:0] ex_rt, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_offset;
  logic          ex_alusrc, ex_regdst, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread;
  logic [1:0]    ex_aluop;
  logic          pc_write, ifid_write;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   m_cnt;
  logic          sat_load = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model of what EX must hold
  logic          m_valid;
  logic [RW-1:0] m_rt, m_rd;
  logic [DW-1:0] m_rd1, m_rd2, m_off;
  logic [7:0]    m_ctrl;

  id_ex_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_offset(id_offset),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_memread(id_memread),
    .id_aluop(id_aluop), .flush(flush),
    .ex_valid(ex_valid), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_offset(ex_offset),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_memread(ex_memread),
    .ex_aluop(ex_aluop), .pc_write(pc_write), .ifid_write(ifid_write)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: does the instruction in ID depend on a non-$0 load sitting in EX?
  function automatic logic model_stall();
    logic load_in_ex;
    logic dep;
    load_in_ex = m_valid && m_ctrl[2] && (m_rt != 0);
    dep        = (m_rt == id_rs) || (m_rt == id_rt);
    return load_in_ex && id_valid && dep && !flush;
  endfunction

  // Model update: what EX holds after each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_rt = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_off = 0; m_ctrl = 0;
`ifdef ID_EX_STALL_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      logic st;
      st = model_stall();
`ifdef ID_EX_STALL_CNT_EN
      if (sat_load) m_cnt = 16'hFFFE;
      if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`endif
      if (st || flush) begin
        m_valid = 0; m_rt = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_off = 0; m_ctrl = 0;
      end else begin
        m_valid = id_valid;
        m_rt = id_rt; m_rd = id_rd; m_rd1 = id_rd1; m_rd2 = id_rd2; m_off = id_offset;
        m_ctrl = id_valid ? {id_alusrc, id_regdst, id_regwrite, id_memtoreg,
                             id_memwrite, id_memread, id_aluop} : 8'h00;
      end
    end
  end

  // Compare DUT against the model every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", 32'(ex_valid), 32'(m_valid));
      chk("m_rt",    32'(ex_rt),    32'(m_rt));
      chk("m_rd",    32'(ex_rd),    32'(m_rd));
      chk("m_rd1",   ex_rd1,        m_rd1);
      chk("m_rd2",   ex_rd2,        m_rd2);
      chk("m_off",   ex_offset,     m_off);
      chk("m_ctrl",  32'({ex_alusrc, ex_regdst, ex_regwrite, ex_memtoreg,
                          ex_memwrite, ex_memread, ex_aluop}), 32'(m_ctrl));
      chk("m_pcw",   32'(pc_write),   32'(!model_stall()));
      chk("m_ifidw", 32'(ifid_write), 32'(!model_stall()));
`ifdef ID_EX_STALL_CNT_EN
      if (!sat_load) chk("m_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    end
  end

  task automatic set_id(input logic v, input logic [RW-1:0] rs, rt, rd,
                        input logic [DW-1:0] a, b, off, input logic [7:0] c,
                        input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = a; id_rd2 = b; id_offset = off;
    {id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_memread, id_aluop} = c;
    flush = fl;
  endtask

  // Advance past the next rising edge; inputs are changed only here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
    #12;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_pcw",   32'(pc_write), 1);
    chk("rst_ifidw", 32'(ifid_write), 1);

    // Pass-through
    tick(); rst = 1'b0;
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h3, 32'h20, C_PASS, 0);
    tick();
    chk("pt_valid", 32'(ex_valid), 1);
    chk("pt_rd1",   ex_rd1, 32'h5);
    chk("pt_rd2",   ex_rd2, 32'h3);
    chk("pt_aluop", 32'(ex_aluop), 32'h2);
    chk("pt_regw",  32'(ex_regwrite), 1);
    chk("pt_rd",    32'(ex_rd), 3);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_regw",  32'(ex_regwrite), 0);
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_rd1",   ex_rd1, 0);
    chk("arst_pcw",   32'(pc_write), 1);
    tick(); rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

    // Load-use stall through rs
    tick();
    set_id(1, 5'd9, 5'd8, 5'd8, 32'h1, 32'h2, 32'h4, C_LW, 0);
    tick();
    set_id(1, 5'd8, 5'd7, 5'd10, 32'h11, 32'h22, 32'h0, C_ADD, 0);
    #1;
    chk("st_pcw",   32'(pc_write), 0);
    chk("st_ifidw", 32'(ifid_write), 0);
    tick();
    chk("st_bub_valid", 32'(ex_valid), 0);
    chk("st_bub_regw",  32'(ex_regwrite), 0);
    chk("st_bub_aluop", 32'(ex_aluop), 0);
    chk("st_after_pcw", 32'(pc_write), 1);
    tick();
    chk("st_reg_valid", 32'(ex_valid), 1);
    chk("st_reg_rd",    32'(ex_rd), 10);
    chk("st_reg_rd1",   ex_rd1, 32'h11);

    // Load to $0 never stalls
    set_id(1, 5'd1, 5'd0, 5'd0, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 5'd4, 0, 0, 0, C_ADD, 0);
    #1;
    chk("z_pcw", 32'(pc_write), 1);
    tick();
    chk("z_valid", 32'(ex_valid), 1);

    // Flush with simultaneous hazard
    set_id(1, 5'd2, 5'd8, 5'd8, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd8, 5'd1, 5'd5, 32'h7, 32'h9, 0, C_ADD, 1);
    #1;
    chk("fl_pcw",   32'(pc_write), 1);
    chk("fl_ifidw", 32'(ifid_write), 1);
    tick();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_regw",  32'(ex_regwrite), 0);
`ifdef ID_EX_STALL_CNT_EN
    chk("fl_cnt", 32'(stall_cnt), 1);
`endif

    // Hazard through rt
    set_id(1, 5'd3, 5'd5, 5'd5, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd3, 5'd5, 5'd6, 0, 0, 0, C_ADD, 0);
    #1;
    chk("rt_pcw", 32'(pc_write), 0);
    tick(); tick();

    // Upstream bubble matching the load: no stall, control masked, data kept
    set_id(1, 5'd3, 5'd6, 5'd6, 0, 0, 0, C_LW, 0);
    tick();
    set_id(0, 5'd6, 5'd6, 5'd7, 32'hABCD, 32'h1234, 32'h8, C_WRSW, 0);
    #1;
    chk("nv_pcw", 32'(pc_write), 1);
    tick();
    chk("nv_valid", 32'(ex_valid), 0);
    chk("nv_regw",  32'(ex_regwrite), 0);
    chk("nv_memw",  32'(ex_memwrite), 0);
    chk("nv_rd1",   ex_rd1, 32'hABCD);

    // Reset while stalled
    set_id(1, 5'd3, 5'd4, 5'd4, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd4, 5'd1, 5'd2, 0, 0, 0, C_ADD, 0);
    #1;
    chk("rs_pcw_st", 32'(pc_write), 0);
    #1 rst = 1'b1;
    #1;
    chk("rs_pcw",   32'(pc_write), 1);
    chk("rs_valid", 32'(ex_valid), 0);
    tick(); rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

`ifdef ID_EX_STALL_CNT_EN
    // Saturation: preload near the top, then two stalls
    tick();
    set_id(1, 5'd1, 5'd8, 5'd8, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd8, 5'd1, 5'd2, 0, 0, 0, C_ADD, 0);
    force dut.stall_cnt_q = 16'hFFFE;
    sat_load = 1'b1;
    #1 release dut.stall_cnt_q;
    tick();
    sat_load = 1'b0;
    chk("sat_1", 32'(stall_cnt), 32'hFFFF);
    tick();
    set_id(1, 5'd1, 5'd8, 5'd8, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 5'd8, 5'd1, 5'd2, 0, 0, 0, C_ADD, 0);
    tick();
    chk("sat_2", 32'(stall_cnt), 32'hFFFF);
`endif

    set_id(0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
